// File: rtl/display_pkg.sv
// Shared types and constants for the output-register display path.
// State enum, segment patterns, digit index type, BCD adjust helper.
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        COMMIT
    } disp_state_t;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Double-dabble correction: add 3 to every nibble >= 5
    function automatic logic [11:0] dabble_adj(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[i*4 +: 4] >= 4'd5)
                r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Combinational BCD to 7-segment (gfedcba, active-high) decoder.
// Ports: bcd[3:0], blank, minus in; seg[6:0] out. minus beats blank.
module seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       minus,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (minus) begin
            seg = SEG_MINUS;
        end else if (!blank) begin
            case (bcd)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/output_display.sv
// Output register reader: byte -> decimal (double dabble) -> 4-digit scan.
// Ports: CLK, nRST, load, value, signed_mode in; busy, seg, an out.
// Optional feature: define SIGNED_MODE_EN for two's-complement display.
module output_display
    import display_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             signed_mode,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [3:0]       an
);

    localparam int CW = $clog2(SCAN_DIV);

    disp_state_t      state, state_nx;
    logic [3:0]       iter;
    logic [11:0]      bcd;
    logic [WIDTH-1:0] bin;
    logic             cur_neg;
    logic             pending;
    logic [WIDTH-1:0] pend_val;
    logic [3:0]       d_ones, d_tens, d_hund;
    logic             d_neg;
    logic [CW-1:0]    scan_cnt;
    digit_idx_t       idx;

    // Source of a new conversion: a load in COMMIT beats the pending slot
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] mag;
    logic             neg;
    logic             take_load;
    logic [11:0]      adj;

    assign take_load = (state != COMMIT) || load;
    assign src_val   = take_load ? value : pend_val;
    assign adj       = dabble_adj(bcd);

`ifdef SIGNED_MODE_EN
    logic pend_sgn;
    logic src_sm;

    assign src_sm = take_load ? signed_mode : pend_sgn;
    assign neg    = src_sm & src_val[WIDTH-1];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            pend_sgn <= 1'b0;
        else if (load && state != IDLE)
            pend_sgn <= signed_mode;
    end
`else
    logic unused_sm;
    assign unused_sm = signed_mode;
    assign neg       = 1'b0;
`endif

    // Magnitude fits in WIDTH unsigned bits, so the most negative value works
    assign mag = neg ? (~src_val + {{(WIDTH-1){1'b0}}, 1'b1}) : src_val;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = (state != IDLE) | pending;
        unique case (state)
            IDLE:    if (load) state_nx = CONVERT;
            CONVERT: if (iter == 4'(WIDTH-1)) state_nx = COMMIT;
            COMMIT:  state_nx = (load || pending) ? CONVERT : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iter     <= 4'd0;
            bcd      <= 12'd0;
            bin      <= '0;
            cur_neg  <= 1'b0;
            pending  <= 1'b0;
            pend_val <= '0;
            d_ones   <= 4'd0;
            d_tens   <= 4'd0;
            d_hund   <= 4'd0;
            d_neg    <= 1'b0;
        end else begin
            if (load && state != IDLE) begin
                pending  <= 1'b1;
                pend_val <= value;
            end
            unique case (state)
                IDLE: begin
                    if (load) begin
                        iter    <= 4'd0;
                        bcd     <= 12'd0;
                        bin     <= mag;
                        cur_neg <= neg;
                    end
                end
                CONVERT: begin
                    bcd  <= {adj[10:0], bin[WIDTH-1]};
                    bin  <= {bin[WIDTH-2:0], 1'b0};
                    iter <= iter + 4'd1;
                end
                COMMIT: begin
                    d_ones <= bcd[3:0];
                    d_tens <= bcd[7:4];
                    d_hund <= bcd[11:8];
                    d_neg  <= cur_neg;
                    if (load || pending) begin
                        pending <= 1'b0;
                        iter    <= 4'd0;
                        bcd     <= 12'd0;
                        bin     <= mag;
                        cur_neg <= neg;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == CW'(SCAN_DIV-1)) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    logic [3:0] m_bcd;
    logic       m_blank;
    logic       m_minus;

    always_comb begin
        m_bcd   = d_ones;
        m_blank = 1'b0;
        m_minus = 1'b0;
        unique case (idx)
            2'd0: m_bcd = d_ones;
            2'd1: begin
                m_bcd   = d_tens;
                m_blank = (d_hund == 4'd0) && (d_tens == 4'd0);
            end
            2'd2: begin
                m_bcd   = d_hund;
                m_blank = (d_hund == 4'd0);
            end
            2'd3: begin
                m_bcd   = 4'd0;
                m_blank = !d_neg;
                m_minus = d_neg;
            end
            default: ;
        endcase
    end

    assign an = 4'b0001 << idx;

    seg_decoder u_dec (
        .bcd   (m_bcd),
        .blank (m_blank),
        .minus (m_minus),
        .seg   (seg)
    );

endmodule
